dcache: RTL

Direct-mapped, write-back, write-allocate data cache placed between the CPU's byte-wide data port and the word-wide data memory. It stalls the CPU through BUSYWAIT only on a miss. On a miss it runs a controller FSM that writes back a dirty victim block, fetches the new block, and installs it. Cache: 8 blocks × 4 bytes, 8-bit CPU address space, 6-bit block address toward memory.

---
 rtl/dcache_pkg.sv | 22 ++
 rtl/dcache_array.sv | 46 ++++
 rtl/dcache.sv | 84 ++++++++
 3 files changed

// File: rtl/dcache_pkg.sv
// dcache_pkg: cache geometry, controller state encoding and ADDRESS field helpers shared by dcache and dcache_array
package dcache_pkg;
  localparam int TAG_W = 3;
  localparam int INDEX_W = 3;
  localparam int OFFSET_W = 2;
  localparam int SETS = 8;
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    FETCH     = 2'd2,
    UPDATE    = 2'd3
  } state_t;
  function automatic logic [TAG_W-1:0] addr_tag(input logic [7:0] a);
    return a[7:5];
  endfunction
  function automatic logic [INDEX_W-1:0] addr_index(input logic [7:0] a);
    return a[4:2];
  endfunction
  function automatic logic [OFFSET_W-1:0] addr_offset(input logic [7:0] a);
    return a[1:0];
  endfunction
endpackage

// File: rtl/dcache_array.sv
// dcache_array: per-set valid/dirty/tag/data store; ports: CLK/RESET, index_i/offset_i select, byte_we_i+byte_i byte store, fill_i+fill_tag_i+fill_data_i block install, valid_o/dirty_o/tag_o/data_o combinational read
module dcache_array
  import dcache_pkg::*;
(
  input  logic                CLK,
  input  logic                RESET,
  input  logic [INDEX_W-1:0]  index_i,
  input  logic [OFFSET_W-1:0] offset_i,
  input  logic                byte_we_i,
  input  logic [7:0]          byte_i,
  input  logic                fill_i,
  input  logic [TAG_W-1:0]    fill_tag_i,
  input  logic [31:0]         fill_data_i,
  output logic                valid_o,
  output logic                dirty_o,
  output logic [TAG_W-1:0]    tag_o,
  output logic [31:0]         data_o
);
  logic [SETS-1:0]  valid_q;
  logic [SETS-1:0]  dirty_q;
  logic [TAG_W-1:0] tag_q [SETS];
  logic [31:0]      data_q [SETS];
  always_ff @(posedge CLK) begin
    if (RESET) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (fill_i) begin
      valid_q[index_i] <= 1'b1;
      dirty_q[index_i] <= 1'b0;
    end else if (byte_we_i) begin
      dirty_q[index_i] <= 1'b1;
    end
  end
  always_ff @(posedge CLK) begin
    if (fill_i) begin
      tag_q[index_i]  <= fill_tag_i;
      data_q[index_i] <= fill_data_i;
    end else if (byte_we_i) begin
      data_q[index_i][{offset_i, 3'b000} +: 8] <= byte_i;
    end
  end
  assign valid_o = valid_q[index_i];
  assign dirty_o = dirty_q[index_i];
  assign tag_o   = tag_q[index_i];
  assign data_o  = data_q[index_i];
endmodule

// File: rtl/dcache.sv
// dcache: direct-mapped write-back write-allocate data cache; CPU side READ/WRITE/ADDRESS/WRITEDATA -> READDATA/BUSYWAIT, memory side mem_read/mem_write/mem_address/mem_writedata <- mem_readdata/mem_busywait
module dcache
  import dcache_pkg::*;
(
  input  logic        CLK,
  input  logic        RESET,
  input  logic        READ,
  input  logic        WRITE,
  input  logic [7:0]  ADDRESS,
  input  logic [7:0]  WRITEDATA,
  output logic [7:0]  READDATA,
  output logic        BUSYWAIT,
  output logic        mem_read,
  output logic        mem_write,
  output logic [5:0]  mem_address,
  output logic [31:0] mem_writedata,
  input  logic [31:0] mem_readdata,
  input  logic        mem_busywait
);
  state_t           state_q, state_d;
  logic [7:0]       addr_q, addr_d;
  logic [31:0]      fill_q, fill_d;
  logic [7:0]       addr;
  logic             idle, req, hit, valid, dirty;
  logic [TAG_W-1:0] tag;
  logic [31:0]      data;
  assign idle = state_q == IDLE;
  // the miss address is captured so the refill finishes even if the CPU drops its request
  assign addr = idle ? ADDRESS : addr_q;
  assign req  = READ | WRITE;
  assign hit  = valid && tag == addr_tag(ADDRESS);
  assign READDATA = valid ? data[{addr_offset(addr), 3'b000} +: 8] : 8'h00;
  dcache_array u_array (
    .CLK        (CLK),
    .RESET      (RESET),
    .index_i    (addr_index(addr)),
    .offset_i   (addr_offset(addr)),
    .byte_we_i  (idle && WRITE && hit),
    .byte_i     (WRITEDATA),
    .fill_i     (state_q == UPDATE),
    .fill_tag_i (addr_tag(addr)),
    .fill_data_i(fill_q),
    .valid_o    (valid),
    .dirty_o    (dirty),
    .tag_o      (tag),
    .data_o     (data)
  );
  always_ff @(posedge CLK) begin
    state_q <= RESET ? IDLE : state_d;
    addr_q  <= addr_d;
    fill_q  <= fill_d;
  end
  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    fill_d        = fill_q;
    BUSYWAIT      = 1'b1;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    mem_address   = '0;
    mem_writedata = '0;
    case (state_q)
      IDLE: begin
        BUSYWAIT = req && !hit;
        addr_d   = ADDRESS;
        state_d  = (req && !hit) ? (dirty ? WRITEBACK : FETCH) : IDLE;
      end
      WRITEBACK: begin
        mem_write     = 1'b1;
        mem_address   = {tag, addr_index(addr_q)};
        mem_writedata = data;
        state_d       = mem_busywait ? WRITEBACK : FETCH;
      end
      FETCH: begin
        mem_read    = 1'b1;
        mem_address = addr_q[7:2];
        // memory only guarantees the block while the read is held, so keep the last beat
        fill_d      = mem_readdata;
        state_d     = mem_busywait ? FETCH : UPDATE;
      end
      UPDATE: state_d = IDLE;
    endcase
  end
endmodule
